// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and shift limit for seq_alu
//
// Purpose: common definitions imported by seq_alu and seq_muldiv_core.
// Ports:   none (package).
package alu_pkg;

    // Legacy single-cycle encodings are kept so the existing control unit
    // needs no change; MULTU/DIVU are the multi-cycle additions.
    localparam logic [3:0] ALU_LUI   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_AND   = 4'b0101;
    localparam logic [3:0] ALU_NOR   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest shift amount of the default 32-bit build; sets SHAMT_W default.
    localparam int MAX_SHAMT = 31;

endpackage

// File: rtl/seq_muldiv_core.sv
// rtl/seq_muldiv_core.sv - iterative shift-add multiplier / restoring divider
//
// Purpose: one result bit per cycle for MULTU (and DIVU when SEQ_ALU_DIVU_EN
//          is defined). Without SEQ_ALU_DIVU_EN the divider is not built.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           load operands and begin (ignored while busy)
//   div             1 = divide, 0 = multiply (sampled with start)
//   a, b            operands (sampled with start)
//   busy            iteration in progress
//   finish          final iteration edge is the next rising edge
//   hi_next,lo_next result of the current step (final result when finish=1)
//   was_div         operation in flight is a divide
//   div0            operation in flight is a divide by zero
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             was_div,
    output logic             div0
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor
    logic [WIDTH-1:0]   hi_q;     // product high / partial remainder
    logic [WIDTH-1:0]   lo_q;     // multiplier / dividend-quotient
    logic               div_in;
    logic               div_q;
    logic               div0_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   hi_step, lo_step;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start) state_n = ST_ITER;
            ST_ITER: if (last)  state_n = ST_DONE;
            ST_DONE: state_n = start ? ST_ITER : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_ITER);
        finish = (state == ST_ITER) && last;
    end

`ifdef SEQ_ALU_DIVU_EN
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;

    assign div_in = div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= 1'b0;
            div0_q <= 1'b0;
        end else if (start && !busy) begin
            div_q  <= div;
            div0_q <= div && (b == '0);
        end
    end

    // Restoring step. A zero divisor always "fits", which naturally yields
    // an all-ones quotient and leaves the dividend in the remainder. When
    // the subtraction is taken the true difference is below the divisor,
    // so a WIDTH-bit subtract is exact.
    always_comb begin
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, opnd_q});
        rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        if (div_q) begin
            hi_step = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], rem_ge};
        end else begin
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end
`else
    logic unused_div;

    assign unused_div = div;
    assign div_in     = 1'b0;
    assign div_q      = 1'b0;
    assign div0_q     = 1'b0;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        hi_step = mul_sum[WIDTH:1];
        lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt    <= '0;
        end else if (start && !busy) begin
            opnd_q <= div_in ? b : a;
            lo_q   <= div_in ? a : b;
            hi_q   <= '0;
            cnt    <= '0;
        end else if (state == ST_ITER) begin
            hi_q   <= hi_step;
            lo_q   <= lo_step;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign hi_next = hi_step;
    assign lo_next = lo_step;
    assign was_div = div_q;
    assign div0    = div0_q;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered MIPS ALU with iterative MULTU/DIVU and HI/LO
//
// Purpose: single-cycle ops complete one edge after accept; MULTU (and DIVU
//          when SEQ_ALU_DIVU_EN is defined) run WIDTH cycles in
//          seq_muldiv_core. Without SEQ_ALU_DIVU_EN, DIVU acts as an
//          unknown opcode.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start_i           request, accepted when busy_o=0
//   alu_operation_i   opcode; a_i, b_i, shamt_i operands (sampled on accept)
//   busy_o            multi-cycle op in progress
//   done_o            one-cycle completion pulse
//   alu_data_o        result / LO;  hi_data_o  HI (MULTU high, DIVU remainder)
//   zero_o            alu_data_o == 0;  div0_o  last DIVU divided by zero
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(MAX_SHAMT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [3:0]         alu_operation_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   alu_data_o,
    output logic [WIDTH-1:0]   hi_data_o,
    output logic               zero_o,
    output logic               div0_o
);

    localparam int HALF = WIDTH / 2;

    logic             accept;
    logic             iter_op;
    logic             core_start;
    logic             core_div;
    logic             core_busy;
    logic             core_finish;
    logic             core_was_div;
    logic             core_div0;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [WIDTH-1:0] single_res;

    // The done cycle is not busy, so a new op may be accepted back-to-back.
    assign accept     = start_i && !core_busy;
    assign core_start = accept && iter_op;
    assign core_div   = (alu_operation_i == ALU_DIVU);

    always_comb begin
        iter_op = (alu_operation_i == ALU_MULTU);
`ifdef SEQ_ALU_DIVU_EN
        if (alu_operation_i == ALU_DIVU) iter_op = 1'b1;
`endif
    end

    always_comb begin
        single_res = '0;
        case (alu_operation_i)
            ALU_LUI: single_res = b_i << HALF;
            ALU_OR:  single_res = a_i | b_i;
            ALU_SLL: single_res = b_i << shamt_i;
            ALU_ADD: single_res = a_i + b_i;
            ALU_SUB: single_res = a_i - b_i;
            ALU_AND: single_res = a_i & b_i;
            ALU_NOR: single_res = ~(a_i | b_i);
            ALU_SRL: single_res = b_i >> shamt_i;
            ALU_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: single_res = '0;
        endcase
    end

    seq_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .start   (core_start),
        .div     (core_div),
        .a       (a_i),
        .b       (b_i),
        .busy    (core_busy),
        .finish  (core_finish),
        .hi_next (core_hi),
        .lo_next (core_lo),
        .was_div (core_was_div),
        .div0    (core_div0)
    );

    // finish can only occur while busy, and single-cycle accept only while
    // idle, so the two update paths never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_o     <= 1'b0;
            alu_data_o <= '0;
            hi_data_o  <= '0;
            zero_o     <= 1'b0;
            div0_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (core_finish) begin
                done_o     <= 1'b1;
                alu_data_o <= core_lo;
                hi_data_o  <= core_hi;
                zero_o     <= (core_lo == '0);
                if (core_was_div) div0_o <= core_div0;
            end else if (accept && !iter_op) begin
                done_o     <= 1'b1;
                alu_data_o <= single_res;
                zero_o     <= (single_res == '0);
            end
        end
    end

    assign busy_o = core_busy;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (honours SEQ_ALU_DIVU_EN)
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_i = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [4:0]    sh = '0;
    logic          busy, done, zero, div0;
    logic [W-1:0]  alu, hi;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [W-1:0]  exp_hi = '0;
    logic          exp_div0 = 1'b0;

    seq_alu #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .alu_operation_i (op),
        .a_i             (a),
        .b_i             (b),
        .shamt_i         (sh),
        .busy_o          (busy),
        .done_o          (done),
        .alu_data_o      (alu),
        .hi_data_o       (hi),
        .zero_o          (zero),
        .div0_o          (div0)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Reference for single-cycle opcodes, from plain arithmetic.
    function automatic logic [W-1:0] ref_single(input logic [3:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y, input logic [4:0] s);
        logic [63:0] wide;
        case (o)
            4'd0: return y * 32'h0001_0000;
            4'd1: return x | y;
            4'd2: begin wide = 64'(y) * (64'd1 << s); return wide[W-1:0]; end
            4'd3: return x + y;
            4'd4: return x - y;
            4'd5: return x & y;
            4'd6: return ~(x | y);
            4'd7: return y / (32'd1 << s);
            4'd8: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    task automatic drive_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [4:0] s);
        @(negedge clk);
        op = o; a = x; b = y; sh = s; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a = $urandom; b = $urandom; sh = 5'($urandom); op = 4'($urandom);
    endtask

    task automatic wait_done(output int cyc, output int busy_bad);
        cyc = 0; busy_bad = 0;
        while (done !== 1'b1 && cyc < W + 8) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start_i = 1'b1; op = 4'd3; a = 32'd1; b = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, alu, hi, zero, div0} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b done=%b alu=%h hi=%h zero=%b div0=%b want all 0",
                     busy, done, alu, hi, zero, div0);
        end
        start_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_release_done got %b want 0", done); end
        exp_hi = '0; exp_div0 = 1'b0;
    endtask

    task automatic test_single_directed();
        logic [3:0]   t_op[5]  = '{4'd3, 4'd4, 4'd8, 4'd0, 4'd7};
        logic [W-1:0] t_a[5]   = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [W-1:0] t_b[5]   = '{32'd1, 32'd5, 32'd1, 32'h0000_1234, 32'h8000_0000};
        logic [4:0]   t_s[5]   = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31};
        logic [W-1:0] t_exp[5] = '{32'h8000_0000, 32'd0, 32'd1, 32'h1234_0000, 32'd1};
        for (int i = 0; i < 5; i++) begin
            drive_op(t_op[i], t_a[i], t_b[i], t_s[i]);
            n_cmp++;
            if ({done, busy, alu, zero, hi, div0} !== {1'b1, 1'b0, t_exp[i], t_exp[i] == '0, exp_hi, exp_div0}) begin
                n_fail++;
                $display("FAIL directed_%0d got done=%b busy=%b alu=%h zero=%b hi=%h div0=%b want alu=%h zero=%b hi=%h",
                         i, done, busy, alu, zero, hi, div0, t_exp[i], t_exp[i] == '0, exp_hi);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({done, busy, alu} !== {1'b0, 1'b0, t_exp[i]}) begin
                n_fail++;
                $display("FAIL directed_hold_%0d got done=%b busy=%b alu=%h want done=0 busy=0 alu=%h",
                         i, done, busy, alu, t_exp[i]);
            end
        end
    endtask

    task automatic test_single_random();
        logic [3:0]   o;
        logic [W-1:0] x, y, e;
        logic [4:0]   s;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            if (o == 4'd9 || o == 4'd10) o = 4'd3;
            x = $urandom; y = $urandom; s = 5'($urandom);
            e = ref_single(o, x, y, s);
            drive_op(o, x, y, s);
            n_cmp++;
            if ({done, busy, alu, zero, hi, div0} !== {1'b1, 1'b0, e, e == '0, exp_hi, exp_div0}) begin
                n_fail++;
                $display("FAIL random_op%0d a=%h b=%h sh=%0d got done=%b busy=%b alu=%h zero=%b hi=%h want alu=%h hi=%h",
                         o, x, y, s, done, busy, alu, zero, hi, e, exp_hi);
            end
        end
    endtask

    task automatic test_multu();
        logic [W-1:0] x, y;
        logic [63:0]  p;
        int           cyc, bb;
        // Directed all-ones product with an ignored start mid-operation.
        drive_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 4'd3; a = 32'd1; b = 32'd2; start_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL multu_midstart got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        start_i = 1'b0;
        wait_done(cyc, bb);
        n_cmp++;
        if (cyc + 7 !== W || bb !== 0) begin
            n_fail++;
            $display("FAIL multu_latency got %0d cycles (%0d not busy) want %0d", cyc + 7, bb, W);
        end
        n_cmp++;
        if ({busy, hi, alu, zero} !== {1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0}) begin
            n_fail++;
            $display("FAIL multu_ones got busy=%b hi=%h lo=%h zero=%b want hi=fffffffe lo=00000001", busy, hi, alu, zero);
        end
        exp_hi = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({done, alu} !== {1'b0, 32'h1}) begin
            n_fail++;
            $display("FAIL multu_single_pulse got done=%b alu=%h want done=0 alu=00000001", done, alu);
        end
        for (int i = 0; i < 4; i++) begin
            x = $urandom; y = (i == 3) ? 32'd0 : $urandom;
            p = 64'(x) * 64'(y);
            drive_op(4'd9, x, y, 5'($urandom));
            wait_done(cyc, bb);
            n_cmp++;
            if (cyc !== W || bb !== 0 || {hi, alu, zero, div0} !== {p, p[W-1:0] == '0, exp_div0}) begin
                n_fail++;
                $display("FAIL multu_rand a=%h b=%h got cyc=%0d hi=%h lo=%h zero=%b want cyc=%0d hi=%h lo=%h",
                         x, y, cyc, hi, alu, zero, W, p[63:32], p[31:0]);
            end
            exp_hi = p[63:32];
        end
    endtask

    task automatic test_divu();
        int cyc, bb;
`ifdef SEQ_ALU_DIVU_EN
        logic [W-1:0] x[6], y[6], q, r;
        logic         z;
        x[0] = 32'd100; y[0] = 32'd7;
        x[1] = 32'h1234; y[1] = 32'd0;
        for (int i = 2; i < 6; i++) begin
            x[i] = $urandom;
            y[i] = (i == 5) ? 32'd0 : (i == 4 ? 32'($urandom_range(1, 300)) : $urandom);
        end
        for (int i = 0; i < 6; i++) begin
            z = (y[i] == '0);
            q = z ? 32'hFFFF_FFFF : x[i] / y[i];
            r = z ? x[i] : x[i] % y[i];
            drive_op(4'd10, x[i], y[i], 5'd0);
            wait_done(cyc, bb);
            n_cmp++;
            if (cyc !== W || bb !== 0 || {alu, hi, div0, zero} !== {q, r, z, q == '0}) begin
                n_fail++;
                $display("FAIL divu_%0d a=%h b=%h got cyc=%0d lo=%h hi=%h div0=%b want cyc=%0d lo=%h hi=%h div0=%b",
                         i, x[i], y[i], cyc, alu, hi, div0, W, q, r, z);
            end
            exp_hi = r; exp_div0 = z;
        end
`else
        drive_op(4'd10, 32'h1234, 32'd0, 5'd0);
        n_cmp++;
        if ({done, busy, alu, zero, hi, div0} !== {1'b1, 1'b0, 32'd0, 1'b1, exp_hi, exp_div0}) begin
            n_fail++;
            $display("FAIL divu_disabled got done=%b busy=%b alu=%h zero=%b hi=%h div0=%b want done=1 alu=0 zero=1 hi=%h",
                     done, busy, alu, zero, hi, div0, exp_hi);
        end
        cyc = 0; bb = 0;
`endif
    endtask

    task automatic test_reset_mid();
        int seen_done;
        drive_op(4'd9, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, alu, hi, zero, div0} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got busy=%b done=%b alu=%h hi=%h zero=%b div0=%b want all 0",
                     busy, done, alu, hi, zero, div0);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_hi = '0; exp_div0 = 1'b0;
        seen_done = 0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL midreset_abort got %0d cycles with done/busy set want 0", seen_done);
        end
        drive_op(4'd3, 32'd2, 32'd3, 5'd0);
        n_cmp++;
        if ({done, alu, hi} !== {1'b1, 32'd5, 32'd0}) begin
            n_fail++;
            $display("FAIL midreset_add got done=%b alu=%h hi=%h want done=1 alu=5 hi=0", done, alu, hi);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y, c, d;
        logic [63:0]  p;
        int           cyc, bb;
        x = $urandom; y = $urandom; c = $urandom; d = $urandom;
        p = 64'(x) * 64'(y);
        drive_op(4'd9, x, y, 5'd0);
        wait_done(cyc, bb);
        n_cmp++;
        if (cyc !== W || {hi, alu} !== p) begin
            n_fail++;
            $display("FAIL b2b_multu got cyc=%0d hi=%h lo=%h want cyc=%0d hi=%h lo=%h",
                     cyc, hi, alu, W, p[63:32], p[31:0]);
        end
        op = 4'd3; a = c; b = d; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        n_cmp++;
        if ({done, busy, alu, hi} !== {1'b1, 1'b0, c + d, p[63:32]}) begin
            n_fail++;
            $display("FAIL b2b_add got done=%b busy=%b alu=%h hi=%h want done=1 busy=0 alu=%h hi=%h",
                     done, busy, alu, hi, c + d, p[63:32]);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({done, alu} !== {1'b0, c + d}) begin
            n_fail++;
            $display("FAIL b2b_pulse got done=%b alu=%h want done=0 alu=%h", done, alu, c + d);
        end
    endtask

    initial begin
        test_reset();
        test_single_directed();
        test_single_random();
        test_multu();
        test_divu();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
